// File: rtl/decrypter.sv
// rtl/decrypter.sv - receive-side decrypter: plain = rotr(cipher, off) ^ rotl(key, off)
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   dataIn      ciphertext word, or key value while prog=1
//   rot_offset  rotation offset accompanying the ciphertext word
//   dataRdyIn   producer valid (level, held until rdyIn drops)
//   cap         consumer capture acknowledge, active-low
//   prog        key-load strobe
//   dataOut     recovered plaintext (registered)
//   rdyIn       block can accept a word
//   dataRdyOut  dataOut valid
//   state       current FSM state (debug)
//   keyRotated  rotl(key, latched offset) (debug)

module decrypter #(
    parameter int DATA_WIDTH = 16,
    parameter int KEY_WIDTH  = 16,
    parameter int ROT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic [ROT_WIDTH-1:0]  rot_offset,
    input  logic                  dataRdyIn,
    input  logic                  cap,
    input  logic                  prog,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  rdyIn,
    output logic                  dataRdyOut,
    output logic [2:0]            state,
    output logic [KEY_WIDTH-1:0]  keyRotated
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READY    = 3'd1,
        S_DECRYPT  = 3'd2,
        S_HOLD     = 3'd3,
        S_WAIT_REL = 3'd4
    } state_t;

    state_t                  cur_state;
    state_t                  next_state;
    logic [KEY_WIDTH-1:0]    key;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic [ROT_WIDTH-1:0]    off_reg;
    logic                    key_load;
    logic                    word_accept;
    logic                    out_load;
    logic [DATA_WIDTH-1:0]   plain;

    // Rotations via a doubled word so the wrapped bits fall out of one shift.
    function automatic logic [DATA_WIDTH-1:0] rotl(input logic [DATA_WIDTH-1:0] x,
                                                   input logic [ROT_WIDTH-1:0]  n);
        logic [2*DATA_WIDTH-1:0] d;
        int unsigned             s;
        s = 32'(n) % 32'(DATA_WIDTH);
        d = {x, x} << s;
        return d[2*DATA_WIDTH-1:DATA_WIDTH];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rotr(input logic [DATA_WIDTH-1:0] x,
                                                   input logic [ROT_WIDTH-1:0]  n);
        logic [2*DATA_WIDTH-1:0] d;
        int unsigned             s;
        s = 32'(n) % 32'(DATA_WIDTH);
        d = {x, x} >> s;
        return d[DATA_WIDTH-1:0];
    endfunction

    assign keyRotated = rotl(key, off_reg);
    assign plain      = rotr(data_reg, off_reg) ^ keyRotated;
    assign state      = cur_state;

    always_comb begin
        next_state  = cur_state;
        key_load    = 1'b0;
        word_accept = 1'b0;
        out_load    = 1'b0;
        case (cur_state)
            S_IDLE: begin
                if (prog) begin
                    key_load   = 1'b1;
                    next_state = S_READY;
                end
            end
            S_READY: begin
                // A key load wins over a word presented in the same cycle.
                if (prog) begin
                    key_load = 1'b1;
                end else if (dataRdyIn) begin
                    word_accept = 1'b1;
                    next_state  = S_DECRYPT;
                end
            end
            S_DECRYPT: begin
                out_load   = 1'b1;
                next_state = S_HOLD;
            end
            S_HOLD: begin
                // Only a definite 0 releases; an unknown cap keeps the word held.
                if (cap == 1'b0) begin
                    next_state = S_WAIT_REL;
                end
            end
            S_WAIT_REL: begin
                // Wait for the producer to drop valid so the same word is not re-accepted.
                if (dataRdyIn == 1'b0) begin
                    next_state = S_READY;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state  <= S_IDLE;
            key        <= '0;
            data_reg   <= '0;
            off_reg    <= '0;
            dataOut    <= '0;
            rdyIn      <= 1'b0;
            dataRdyOut <= 1'b0;
        end else begin
            cur_state <= next_state;
            if (key_load) begin
                key <= dataIn;
            end
            if (word_accept) begin
                data_reg <= dataIn;
                off_reg  <= rot_offset;
            end
            if (out_load) begin
                dataOut <= plain;
            end
            // Handshake flags track the state being entered, so they are mutually exclusive.
            rdyIn      <= (next_state == S_READY);
            dataRdyOut <= (next_state == S_HOLD);
        end
    end

endmodule

// File: tb/tb_decrypter.sv
// tb/tb_decrypter.sv - scoreboard testbench for decrypter

module tb_decrypter;

    logic        clk;
    logic        reset;
    logic [15:0] dataIn;
    logic [3:0]  rot_offset;
    logic        dataRdyIn;
    logic        cap;
    logic        prog;
    logic [15:0] dataOut;
    logic        rdyIn;
    logic        dataRdyOut;
    logic [2:0]  state;
    logic [15:0] keyRotated;

    int          n_tests;
    int          n_fail;
    logic [15:0] exp_q[$];
    int          hold_cycles;
    logic [15:0] m_key;

    decrypter #(.DATA_WIDTH(16), .KEY_WIDTH(16), .ROT_WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .dataIn     (dataIn),
        .rot_offset (rot_offset),
        .dataRdyIn  (dataRdyIn),
        .cap        (cap),
        .prog       (prog),
        .dataOut    (dataOut),
        .rdyIn      (rdyIn),
        .dataRdyOut (dataRdyOut),
        .state      (state),
        .keyRotated (keyRotated)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference model in plain integer arithmetic.
    function automatic logic [15:0] m_rotl(input logic [15:0] x, input int n);
        int s;
        int v;
        s = n % 16;
        v = int'(x);
        return 16'(((v << s) | (v >> (16 - s))) & 32'hFFFF);
    endfunction

    function automatic logic [15:0] m_encrypt(input logic [15:0] p, input logic [15:0] k, input int off);
        return m_rotl(p ^ m_rotl(k, off), off);
    endfunction

    task automatic wait_rdy();
        for (int i = 0; i < 100; i++) begin
            if (rdyIn === 1'b1) return;
            @(negedge clk);
        end
        check("wait_rdyIn_timeout", {31'd0, rdyIn}, 32'd1);
    endtask

    task automatic wait_out();
        for (int i = 0; i < 100; i++) begin
            if (dataRdyOut === 1'b1) return;
            @(negedge clk);
        end
        check("wait_dataRdyOut_timeout", {31'd0, dataRdyOut}, 32'd1);
    endtask

    task automatic load_key(input logic [15:0] k);
        prog   = 1'b1;
        dataIn = k;
        @(negedge clk);
        prog   = 1'b0;
        m_key  = k;
    endtask

    task automatic send(input logic [15:0] c, input logic [3:0] o, input logic [15:0] e);
        wait_rdy();
        dataIn     = c;
        rot_offset = o;
        dataRdyIn  = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        dataRdyIn = 1'b0;
    endtask

    // Consumer/monitor: compares each new output against the scoreboard and drives cap.
    initial begin
        bit          seen;
        int          hc;
        logic [15:0] held;
        seen = 0;
        hc   = 0;
        held = '0;
        forever begin
            @(negedge clk);
            cap = 1'b1;
            if (reset === 1'b1) begin
                check("rdy_exclusive", {31'd0, rdyIn & dataRdyOut}, 32'd0);
                if (dataRdyOut !== 1'b1) begin
                    seen = 0;
                end else if (!seen) begin
                    seen = 1;
                    hc   = 0;
                    held = dataOut;
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_output: got %h expected none", dataOut);
                    end else begin
                        logic [15:0] e;
                        n_tests--;
                        e = exp_q.pop_front();
                        check("data_out", {16'd0, dataOut}, {16'd0, e});
                    end
                end else begin
                    check("hold_stable", {16'd0, dataOut}, {16'd0, held});
                end
                if (seen) begin
                    if (hc >= hold_cycles) cap = 1'b0;
                    hc++;
                end
            end else begin
                seen = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] p;
        logic [3:0]  o;
        n_tests     = 0;
        n_fail      = 0;
        hold_cycles = 2;
        m_key       = '0;
        reset       = 1'b0;
        dataIn      = '0;
        rot_offset  = '0;
        dataRdyIn   = 1'b0;
        prog        = 1'b0;
        cap         = 1'b1;

        // 1. reset and key load
        #10;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_state", {29'd0, state}, 32'd0);
        check("reset_rdyIn", {31'd0, rdyIn}, 32'd0);
        check("reset_dataRdyOut", {31'd0, dataRdyOut}, 32'd0);
        check("reset_dataOut", {16'd0, dataOut}, 32'd0);
        check("reset_keyRotated", {16'd0, keyRotated}, 32'd0);
        dataRdyIn = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ignores_word", {29'd0, state}, 32'd0);
        dataRdyIn = 1'b0;
        load_key(16'hCCE3);
        check("keyload_state", {29'd0, state}, 32'd1);
        check("keyload_rdyIn", {31'd0, rdyIn}, 32'd1);

        // 2/4. directed word, long hold, valid held through release
        hold_cycles = 5;
        dataIn     = 16'hF0F0;
        rot_offset = 4'd7;
        dataRdyIn  = 1'b1;
        exp_q.push_back(16'h9007);
        @(negedge clk);
        check("accept_rdyIn_fall", {31'd0, rdyIn}, 32'd0);
        check("accept_state", {29'd0, state}, 32'd2);
        check("accept_no_out_yet", {31'd0, dataRdyOut}, 32'd0);
        check("keyRotated_7", {16'd0, keyRotated}, 32'h71E6);
        @(negedge clk);
        check("latency_dataRdyOut", {31'd0, dataRdyOut}, 32'd1);
        check("latency_state", {29'd0, state}, 32'd3);
        check("dir_dataOut", {16'd0, dataOut}, 32'h9007);
        repeat (5) @(negedge clk);
        check("hold_dataRdyOut", {31'd0, dataRdyOut}, 32'd1);
        check("hold_dataOut", {16'd0, dataOut}, 32'h9007);
        @(negedge clk);
        check("release_dataRdyOut", {31'd0, dataRdyOut}, 32'd0);
        check("release_state", {29'd0, state}, 32'd4);
        repeat (3) begin
            @(negedge clk);
            check("waitrel_rdyIn", {31'd0, rdyIn}, 32'd0);
            check("waitrel_state", {29'd0, state}, 32'd4);
        end
        dataRdyIn = 1'b0;
        @(negedge clk);
        check("waitrel_exit_rdyIn", {31'd0, rdyIn}, 32'd1);
        check("dataOut_kept", {16'd0, dataOut}, 32'h9007);

        // 3. offset zero
        hold_cycles = 1;
        send(16'h0000, 4'd0, 16'hCCE3);
        send(16'hCCE3, 4'd0, 16'h0000);

        // 5. prog priority in READY, prog ignored in HOLD
        wait_rdy();
        prog      = 1'b1;
        dataRdyIn = 1'b1;
        dataIn    = 16'h1234;
        @(negedge clk);
        prog      = 1'b0;
        dataRdyIn = 1'b0;
        m_key     = 16'h1234;
        check("prio_state", {29'd0, state}, 32'd1);
        check("prio_rdyIn", {31'd0, rdyIn}, 32'd1);
        check("prio_key", {16'd0, keyRotated}, 32'h1234);
        hold_cycles = 3;
        send(16'h0000, 4'd0, 16'h1234);
        wait_out();
        prog   = 1'b1;
        dataIn = 16'hFFFF;
        @(negedge clk);
        prog = 1'b0;
        check("hold_prog_ignored", {16'd0, keyRotated}, 32'h1234);
        send(16'h1234, 4'd0, 16'h0000);

        // Randomised traffic with occasional key reloads
        for (int i = 0; i < 40; i++) begin
            hold_cycles = $urandom_range(0, 3);
            if ($urandom_range(0, 5) == 0) begin
                wait_rdy();
                load_key(16'($urandom));
            end
            p = 16'($urandom);
            o = 4'($urandom);
            send(m_encrypt(p, m_key, int'(o)), o, p);
        end

        // 6. asynchronous reset mid-HOLD
        hold_cycles = 1000;
        p = 16'hA5C3;
        send(m_encrypt(p, m_key, 5), 4'd5, p);
        wait_out();
        #2;
        reset = 1'b0;
        #1;
        check("areset_dataRdyOut", {31'd0, dataRdyOut}, 32'd0);
        check("areset_rdyIn", {31'd0, rdyIn}, 32'd0);
        check("areset_dataOut", {16'd0, dataOut}, 32'd0);
        check("areset_state", {29'd0, state}, 32'd0);
        check("areset_keyRotated", {16'd0, keyRotated}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        hold_cycles = 1;
        repeat (3) @(negedge clk);
        check("post_reset_rdyIn", {31'd0, rdyIn}, 32'd0);
        check("post_reset_state", {29'd0, state}, 32'd0);
        load_key(16'h5A5A);
        check("reload_rdyIn", {31'd0, rdyIn}, 32'd1);
        p = 16'h0F1E;
        send(m_encrypt(p, m_key, 12), 4'd12, p);
        wait_rdy();
        repeat (2) @(negedge clk);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
